// File: rtl/riscv_pkg.sv
// Shared encodings for the MEM stage: writeback source select, load/store size codes
// and the LSU FSM state type.
package riscv_pkg;

  localparam logic [1:0] WSEL_ALU   = 2'b00;
  localparam logic [1:0] WSEL_MEM   = 2'b01;
  localparam logic [1:0] WSEL_WDATA = 2'b10;
  localparam logic [1:0] WSEL_RSV   = 2'b11;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  typedef enum logic {IDLE, BUSY} lsu_state_e;

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane handling for the data bus: store byte enables, store data
// replication and load lane extraction with sign/zero extension.
module mem_lsu_align
  import riscv_pkg::*;
(
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
  assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_be    = '1;
    o_wdata = i_wdata;
    if (i_store) begin
      case (i_funct3[1:0])
        2'b00: begin
          o_be    = 4'b0001 << i_addr;
          o_wdata = {4{i_wdata[7:0]}};
        end
        2'b01: begin
          o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
          o_wdata = {2{i_wdata[15:0]}};
        end
        default: o_be = '1;
      endcase
    end
  end

  always_comb begin
    o_ldata = i_rdata;
    case (i_funct3)
      FUNCT3_B:  o_ldata = {{24{w_byte[7]}}, w_byte};
      FUNCT3_BU: o_ldata = {24'd0, w_byte};
      FUNCT3_H:  o_ldata = {{16{w_half[15]}}, w_half};
      FUNCT3_HU: o_ldata = {16'd0, w_half};
      default:   o_ldata = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: req/ack data-bus access with upstream stall, writeback select and MEM/WB register.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rf_we,
  input  logic [1:0]        rf_wsel,
  input  logic              ram_we,
  input  logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic [4:0]        rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] alu_c,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              wb_we,
  output logic [4:0]        wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              misalign
);

  lsu_state_e        r_state, w_next;
  logic              w_mem_op, w_mis, w_go;
  logic [DATA_W-1:0] w_ldata, w_wbval;

  assign w_mem_op = ram_we | (rf_we & (rf_wsel == WSEL_MEM));

`ifdef MISALIGN_TRAP_EN
  assign w_mis = w_mem_op &
                 (((mem_funct3[1:0] == 2'b01) & alu_c[0]) |
                  ((mem_funct3[1:0] == 2'b10) & (alu_c[1:0] != 2'b00)));
`else
  assign w_mis = 1'b0;
`endif

  assign w_go     = w_mem_op & ~w_mis;
  assign dm_we    = dm_req & ram_we;
  assign dm_addr  = {alu_c[ADDR_W-1:2], 2'b00};

  mem_lsu_align u_align (
    .i_store  (ram_we),
    .i_funct3 (mem_funct3),
    .i_addr   (alu_c[1:0]),
    .i_wdata  (rf_rdata2),
    .i_rdata  (dm_rdata),
    .o_be     (dm_be),
    .o_wdata  (dm_wdata),
    .o_ldata  (w_ldata)
  );

  // Zero-wait ack completes in IDLE without ever entering BUSY
  always_comb begin
    w_next = r_state;
    dm_req = 1'b0;
    stall  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_go) begin
          dm_req = 1'b1;
          if (!dm_ack) begin
            stall  = 1'b1;
            w_next = BUSY;
          end
        end
      end
      BUSY: begin
        dm_req = 1'b1;
        stall  = ~dm_ack;
        if (dm_ack) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    case (rf_wsel)
      WSEL_MEM:   w_wbval = w_ldata;
      WSEL_WDATA: w_wbval = rf_wdata;
      default:    w_wbval = alu_c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      wb_we    <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (stall) begin
        wb_we <= 1'b0;
      end else begin
        wb_we    <= rf_we & ~ram_we & ~w_mis & (rf_waddr != 5'd0);
        wb_waddr <= rf_waddr;
        wb_wdata <= w_wbval;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic r_mis;
  always_ff @(posedge clk) begin
    if (!rst_n) r_mis <= 1'b0;
    else        r_mis <= w_mis & (r_state == IDLE);
  end
  assign misalign = r_mis;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu; the misalign case follows MISALIGN_TRAP_EN.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rf_we;
  logic [1:0]  rf_wsel;
  logic        ram_we;
  logic [2:0]  mem_funct3;
  logic [31:0] rf_rdata2;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] alu_c;
  logic        stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        misalign;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rf_we(rf_we), .rf_wsel(rf_wsel), .ram_we(ram_we),
    .mem_funct3(mem_funct3), .rf_rdata2(rf_rdata2), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .alu_c(alu_c), .stall(stall), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .wb_we(wb_we), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .misalign(misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nop();
    rf_we = 1'b0; rf_wsel = 2'b00; ram_we = 1'b0; mem_funct3 = 3'b010;
    rf_rdata2 = '0; rf_waddr = '0; rf_wdata = '0; alu_c = '0; dm_ack = 1'b0;
  endtask

  task automatic after_edge();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; dm_rdata = '0;
    nop();
    after_edge(); after_edge();
    chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst_wb_waddr", {27'd0, wb_waddr}, 32'd0);
    chk("rst_wb_wdata", wb_wdata, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_dm_req", {31'd0, dm_req}, 32'd0);

    // 1: ALU op
    @(negedge clk); rst_n = 1'b1;
    rf_we = 1'b1; rf_wsel = 2'b00; alu_c = 32'h1234; rf_waddr = 5'd5;
    #1;
    chk("alu_dm_req", {31'd0, dm_req}, 32'd0);
    chk("alu_stall", {31'd0, stall}, 32'd0);
    after_edge();
    chk("alu_wb_we", {31'd0, wb_we}, 32'd1);
    chk("alu_wb_waddr", {27'd0, wb_waddr}, 32'd5);
    chk("alu_wb_wdata", wb_wdata, 32'h1234);

    // 2: SB with ack after 3 stall cycles
    @(negedge clk); nop();
    ram_we = 1'b1; rf_we = 1'b1; mem_funct3 = 3'b000; rf_rdata2 = 32'h000000A5;
    alu_c = 32'h1002; rf_waddr = 5'd9;
    #1;
    chk("sb_req", {31'd0, dm_req}, 32'd1);
    chk("sb_we", {31'd0, dm_we}, 32'd1);
    chk("sb_addr", dm_addr, 32'h1000);
    chk("sb_be", {28'd0, dm_be}, 32'h4);
    chk("sb_wdata", dm_wdata, 32'hA5A5A5A5);
    chk("sb_stall0", {31'd0, stall}, 32'd1);
    after_edge();
    chk("sb_bubble", {31'd0, wb_we}, 32'd0);
    @(negedge clk); #1;
    chk("sb_stall1", {31'd0, stall}, 32'd1);
    chk("sb_req1", {31'd0, dm_req}, 32'd1);
    chk("sb_addr1", dm_addr, 32'h1000);
    @(negedge clk); #1;
    chk("sb_stall2", {31'd0, stall}, 32'd1);
    @(negedge clk); dm_ack = 1'b1; #1;
    chk("sb_stall3", {31'd0, stall}, 32'd0);
    chk("sb_req3", {31'd0, dm_req}, 32'd1);
    after_edge();
    chk("sb_wb_we", {31'd0, wb_we}, 32'd0);

    // ack with no request is ignored; wsel=10 passes rf_wdata
    @(negedge clk); nop();
    dm_ack = 1'b1; rf_we = 1'b1; rf_wsel = 2'b10; rf_wdata = 32'h00000104; rf_waddr = 5'd1;
    #1;
    chk("wdata_req", {31'd0, dm_req}, 32'd0);
    after_edge();
    chk("wdata_wb", wb_wdata, 32'h104);
    chk("wdata_we", {31'd0, wb_we}, 32'd1);

    // SH upper half, SW
    @(negedge clk); nop();
    ram_we = 1'b1; mem_funct3 = 3'b001; rf_rdata2 = 32'hCAFE1357; alu_c = 32'h0000_0106; dm_ack = 1'b1;
    #1;
    chk("sh_be", {28'd0, dm_be}, 32'hC);
    chk("sh_wdata", dm_wdata, 32'h13571357);
    chk("sh_addr", dm_addr, 32'h104);
    @(negedge clk); mem_funct3 = 3'b010; #1;
    chk("sw_be", {28'd0, dm_be}, 32'hF);
    chk("sw_wdata", dm_wdata, 32'hCAFE1357);

    // 3: LB / LBU zero-wait
    @(negedge clk); nop();
    rf_we = 1'b1; rf_wsel = 2'b01; mem_funct3 = 3'b000; alu_c = 32'h2003;
    rf_waddr = 5'd7; dm_rdata = 32'h80FFFFFF; dm_ack = 1'b1;
    #1;
    chk("lb_req", {31'd0, dm_req}, 32'd1);
    chk("lb_dm_we", {31'd0, dm_we}, 32'd0);
    chk("lb_be", {28'd0, dm_be}, 32'hF);
    chk("lb_stall", {31'd0, stall}, 32'd0);
    after_edge();
    chk("lb_wb_we", {31'd0, wb_we}, 32'd1);
    chk("lb_waddr", {27'd0, wb_waddr}, 32'd7);
    chk("lb_data", wb_wdata, 32'hFFFFFF80);
    @(negedge clk); mem_funct3 = 3'b100;
    after_edge();
    chk("lbu_data", wb_wdata, 32'h00000080);

    // 4: LH / LHU upper half
    @(negedge clk); mem_funct3 = 3'b001; alu_c = 32'h2002; dm_rdata = 32'h80011234;
    after_edge();
    chk("lh_data", wb_wdata, 32'hFFFF8001);
    @(negedge clk); mem_funct3 = 3'b101;
    after_edge();
    chk("lhu_data", wb_wdata, 32'h00008001);

    // load to x0 never writes
    @(negedge clk); rf_waddr = 5'd0;
    after_edge();
    chk("x0_wb_we", {31'd0, wb_we}, 32'd0);

    // 5: reset while BUSY, then late ack
    @(negedge clk); nop();
    rf_we = 1'b1; rf_wsel = 2'b01; mem_funct3 = 3'b010; alu_c = 32'h4000; rf_waddr = 5'd3;
    #1;
    chk("busy_stall", {31'd0, stall}, 32'd1);
    @(negedge clk); rst_n = 1'b0; nop();
    after_edge();
    chk("rb_req", {31'd0, dm_req}, 32'd0);
    chk("rb_stall", {31'd0, stall}, 32'd0);
    chk("rb_wb_we", {31'd0, wb_we}, 32'd0);
    @(negedge clk); rst_n = 1'b1; dm_ack = 1'b1; #1;
    chk("late_ack_req", {31'd0, dm_req}, 32'd0);
    after_edge();
    chk("late_ack_wb_we", {31'd0, wb_we}, 32'd0);

    // 6: LW at 0x3002
    @(negedge clk); nop();
    rf_we = 1'b1; rf_wsel = 2'b01; mem_funct3 = 3'b010; alu_c = 32'h3002;
    rf_waddr = 5'd4; dm_rdata = 32'hDEADBEEF; dm_ack = 1'b1;
    #1;
`ifdef MISALIGN_TRAP_EN
    chk("mis_req", {31'd0, dm_req}, 32'd0);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    after_edge();
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_wb_we", {31'd0, wb_we}, 32'd0);
    @(negedge clk); nop();
    after_edge();
    chk("mis_clear", {31'd0, misalign}, 32'd0);
`else
    chk("lw_req", {31'd0, dm_req}, 32'd1);
    chk("lw_addr", dm_addr, 32'h3000);
    after_edge();
    chk("lw_data", wb_wdata, 32'hDEADBEEF);
    chk("lw_wb_we", {31'd0, wb_we}, 32'd1);
    chk("lw_misalign", {31'd0, misalign}, 32'd0);
`endif

    @(negedge clk); nop();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
